// File: rtl/comm_pkg.sv
// Shared types and constants for the copter-side command link.
package comm_pkg;

    typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} frame_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [0:0] {TX_IDLE, TX_SHIFT} tx_state_t;

    localparam logic [7:0] POS_ACK       = 8'hA5;
    localparam logic [7:0] CMD_SET_PTCH  = 8'h02;
    localparam logic [7:0] CMD_SET_THRST = 8'h05;
    localparam logic [7:0] CMD_CALIBRATE = 8'h06;
    localparam int         DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Command/response handshake between the responder and the command-config logic.
interface uart_cmd_responder_if;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        resp_sent;
    logic        tx_busy;

    modport master (output clr_cmd_rdy, send_resp, resp,
                    input  cmd_rdy, cmd, data, resp_sent, tx_busy);
    modport slave  (input  clr_cmd_rdy, send_resp, resp,
                    output cmd_rdy, cmd, data, resp_sent, tx_busy);
endinterface

// File: rtl/uart_byte_xcvr.sv
// Byte-level 8N1 UART receiver and transmitter, full-duplex, BAUD_DIV clocks per bit.
module uart_byte_xcvr import comm_pkg::*; #(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       tx_o,
    input  logic       send_i,
    input  logic [7:0] tx_byte_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_rdy_o,
    output logic       tx_busy_o,
    output logic       tx_done_o
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

    logic [1:0]    rx_sync_q;
    logic          rx_prev_q;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_baud_q, rx_baud_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          byte_rdy_q, byte_rdy_d;
    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_baud_q, tx_baud_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic          rx_s;

    assign rx_s = rx_sync_q[1];

    // State registers for both directions; the synchroniser idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= 4'd0;
            rx_shift_q <= 8'h00;
            byte_rdy_q <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= 4'd0;
            tx_shift_q <= 10'h3FF;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rx_i};
            rx_prev_q  <= rx_s;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            byte_rdy_q <= byte_rdy_d;
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Receiver: start bit re-checked at half-bit so a glitch returns to idle.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_rdy_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_baud_d = '0;
                rx_bit_d  = 4'd0;
                if (rx_prev_q && !rx_s) rx_state_d = RX_START;
                else                    rx_state_d = RX_IDLE;
            end
            RX_START: begin
                if (rx_baud_q == HALF) begin
                    rx_baud_d  = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_baud_q == FULL) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 4'd7) begin
                        rx_bit_d   = 4'd0;
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (rx_baud_q == FULL) begin
                    rx_baud_d  = '0;
                    rx_state_d = RX_IDLE;
                    byte_rdy_d = rx_s;
                end else begin
                    rx_state_d = RX_STOP;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Transmitter: shift register holds {stop, data, start}, bit index 9 is the stop bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_baud_d = '0;
                tx_bit_d  = 4'd0;
                if (send_i) begin
                    tx_shift_d = {1'b1, tx_byte_i, 1'b0};
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    tx_state_d = TX_SHIFT;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            TX_SHIFT: begin
                if (tx_baud_q == FULL) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_d       = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_d       = tx_shift_q[1];
                        tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    end
                end else begin
                    tx_state_d = TX_SHIFT;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign rx_byte_o  = rx_shift_q;
    assign byte_rdy_o = byte_rdy_q;
    assign tx_o       = tx_q;
    assign tx_busy_o  = busy_q;
    assign tx_done_o  = done_q;

endmodule

// File: rtl/uart_cmd_responder.sv
// Copter-side command link: 3-byte frame assembly over UART plus a one-byte response.
// Optional inter-byte frame timeout enabled by defining FRAME_TIMEOUT_EN.
module uart_cmd_responder import comm_pkg::*; #(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
`ifdef FRAME_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 65536
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic RX,
    output logic TX,
    uart_cmd_responder_if.slave bus
);
    frame_state_t state_q, state_d;
    logic [7:0]   cmd_sh_q, cmd_sh_d, hi_sh_q, hi_sh_d, cmd_q, cmd_d;
    logic [15:0]  data_q, data_d;
    logic         rdy_q, rdy_d;
    logic [7:0]   rx_byte_s;
    logic         byte_rdy_s;
`ifdef FRAME_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYC);
    logic [GW-1:0] gap_q, gap_d;
`endif

    uart_byte_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (RX),
        .tx_o       (TX),
        .send_i     (bus.send_resp),
        .tx_byte_i  (bus.resp),
        .rx_byte_o  (rx_byte_s),
        .byte_rdy_o (byte_rdy_s),
        .tx_busy_o  (bus.tx_busy),
        .tx_done_o  (bus.resp_sent)
    );

    // Frame FSM state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_CMD;
            cmd_sh_q <= 8'h00;
            hi_sh_q  <= 8'h00;
            cmd_q    <= 8'h00;
            data_q   <= 16'h0000;
            rdy_q    <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            gap_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cmd_sh_q <= cmd_sh_d;
            hi_sh_q  <= hi_sh_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
`ifdef FRAME_TIMEOUT_EN
            gap_q    <= gap_d;
`endif
        end
    end

    // Frame assembly; a frame completion sets cmd_rdy after any clear so set wins.
    always_comb begin
        state_d  = state_q;
        cmd_sh_d = cmd_sh_q;
        hi_sh_d  = hi_sh_q;
        cmd_d    = cmd_q;
        data_d   = data_q;
        if (bus.clr_cmd_rdy) rdy_d = 1'b0;
        else                 rdy_d = rdy_q;
        case (state_q)
            WAIT_CMD: begin
                if (byte_rdy_s) begin
                    cmd_sh_d = rx_byte_s;
                    rdy_d    = 1'b0;
                    state_d  = WAIT_HI;
                end else begin
                    state_d = WAIT_CMD;
                end
            end
            WAIT_HI: begin
                if (byte_rdy_s) begin
                    hi_sh_d = rx_byte_s;
                    state_d = WAIT_LO;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_LO: begin
                if (byte_rdy_s) begin
                    cmd_d   = cmd_sh_q;
                    data_d  = {hi_sh_q, rx_byte_s};
                    rdy_d   = 1'b1;
                    state_d = WAIT_CMD;
                end else begin
                    state_d = WAIT_LO;
                end
            end
            default: state_d = WAIT_CMD;
        endcase
`ifdef FRAME_TIMEOUT_EN
        if (state_q != WAIT_CMD && !byte_rdy_s) begin
            if (gap_q == GW'(TIMEOUT_CYC - 1)) begin
                gap_d    = '0;
                state_d  = WAIT_CMD;
                cmd_sh_d = 8'h00;
                hi_sh_d  = 8'h00;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end else begin
            gap_d = '0;
        end
`else
        // Without the timeout the FSM waits indefinitely for the remaining bytes.
`endif
    end

    assign bus.cmd_rdy = rdy_q;
    assign bus.cmd     = cmd_q;
    assign bus.data    = data_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder at a short baud divisor; FRAME_TIMEOUT_EN adds the timeout case.
module tb_uart_cmd_responder;
    import comm_pkg::*;

    localparam int B  = 16;
    localparam int TO = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;
    int   n_vec = 0;
    int   n_err = 0;
    logic [9:0] exp_wave;

    uart_cmd_responder_if bus();

    uart_cmd_responder #(
        .BAUD_DIV(B)
`ifdef FRAME_TIMEOUT_EN
        , .TIMEOUT_CYC(TO)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .RX  (rx),
        .TX  (tx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        cyc(B);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(B);
        end
        rx = stop_ok;
        cyc(B);
        rx = 1'b1;
        cyc(2 * B);
    endtask

    task automatic pulse_clr();
        bus.clr_cmd_rdy = 1'b1;
        cyc(1);
        bus.clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.resp        = 8'h00;
        exp_wave        = 10'b1101001010;

        // Reset state
        cyc(2);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        chk("rst_cmd", {24'd0, bus.cmd}, 32'h00);
        chk("rst_data", {16'd0, bus.data}, 32'h0000);
        chk("rst_busy", {31'd0, bus.tx_busy}, 32'd0);
        chk("rst_sent", {31'd0, bus.resp_sent}, 32'd0);
        rst = 1'b0;
        cyc(4);

        // Frame 0x05,0x01,0xFF; nothing visible until the third byte
        send_byte(CMD_SET_THRST, 1'b1);
        send_byte(8'h01, 1'b1);
        chk("partial_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        chk("partial_cmd", {24'd0, bus.cmd}, 32'h00);
        send_byte(8'hFF, 1'b1);
        chk("f1_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("f1_cmd", {24'd0, bus.cmd}, 32'h05);
        chk("f1_data", {16'd0, bus.data}, 32'h01FF);
        pulse_clr();
        chk("clr_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        chk("clr_cmd", {24'd0, bus.cmd}, 32'h05);
        chk("clr_data", {16'd0, bus.data}, 32'h01FF);

        // Response 0xA5: check first and last cycle of every bit, ignore a mid-frame request
        bus.resp      = POS_ACK;
        bus.send_resp = 1'b1;
        cyc(1);
        bus.send_resp = 1'b0;
        chk("tx_busy_on", {31'd0, bus.tx_busy}, 32'd1);
        for (int c = 0; c <= 10 * B + 1; c++) begin
            if (c < 10 * B && ((c % B) == 0 || (c % B) == B - 1))
                chk($sformatf("tx_bit%0d_c%0d", c / B, c % B), {31'd0, tx}, {31'd0, exp_wave[c / B]});
            if (c == 10 * B - 1)
                chk("sent_early", {31'd0, bus.resp_sent}, 32'd0);
            if (c == 10 * B) begin
                chk("sent_pulse", {31'd0, bus.resp_sent}, 32'd1);
                chk("busy_off", {31'd0, bus.tx_busy}, 32'd0);
                chk("tx_idle", {31'd0, tx}, 32'd1);
            end
            if (c == 10 * B + 1)
                chk("sent_once", {31'd0, bus.resp_sent}, 32'd0);
            bus.send_resp = (c == 3 * B + 2);
            if (c == 3 * B + 2) bus.resp = 8'h00;
            cyc(1);
        end
        cyc(3);
        chk("no_queue_busy", {31'd0, bus.tx_busy}, 32'd0);
        chk("no_queue_tx", {31'd0, tx}, 32'd1);

        // Framing error on the second byte keeps the FSM waiting for the high byte
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b1);
        chk("ferr_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        send_byte(8'h50, 1'b1);
        chk("ferr_done", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("ferr_cmd", {24'd0, bus.cmd}, 32'h04);
        chk("ferr_data", {16'd0, bus.data}, 32'h0050);

        // Back-to-back frames without a clear
        send_byte(CMD_SET_PTCH, 1'b1);
        chk("stale_drop0", {31'd0, bus.cmd_rdy}, 32'd0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        chk("b2b1_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("b2b1_cmd", {24'd0, bus.cmd}, 32'h02);
        chk("b2b1_data", {16'd0, bus.data}, 32'h1234);
        send_byte(CMD_CALIBRATE, 1'b1);
        chk("stale_drop", {31'd0, bus.cmd_rdy}, 32'd0);
        chk("stale_cmd", {24'd0, bus.cmd}, 32'h02);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("b2b2_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("b2b2_cmd", {24'd0, bus.cmd}, 32'h06);
        chk("b2b2_data", {16'd0, bus.data}, 32'h0000);

        // Asynchronous reset mid-TX and mid-RX-byte
        bus.resp      = 8'h3C;
        bus.send_resp = 1'b1;
        cyc(1);
        bus.send_resp = 1'b0;
        rx = 1'b0;
        cyc(3 * B);
        chk("pre_rst_busy", {31'd0, bus.tx_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_tx", {31'd0, tx}, 32'd1);
        chk("arst_busy", {31'd0, bus.tx_busy}, 32'd0);
        chk("arst_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        chk("arst_data", {16'd0, bus.data}, 32'h0000);
        rx = 1'b1;
        cyc(2);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c == 0 || c == 50 || c == 99)
                chk($sformatf("idle_tx_c%0d", c), {31'd0, tx}, 32'd1);
            cyc(1);
        end
        send_byte(8'h06, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        chk("post_rst_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("post_rst_cmd", {24'd0, bus.cmd}, 32'h06);
        chk("post_rst_data", {16'd0, bus.data}, 32'hABCD);

`ifdef FRAME_TIMEOUT_EN
        // A lone byte ages out; the following byte starts a fresh frame
        send_byte(CMD_SET_THRST, 1'b1);
        cyc(TO + 100);
        send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1);
        chk("to_rdy_wait", {31'd0, bus.cmd_rdy}, 32'd0);
        chk("to_cmd_held", {24'd0, bus.cmd}, 32'h06);
        send_byte(8'h00, 1'b1);
        chk("to_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("to_cmd", {24'd0, bus.cmd}, 32'h01);
        chk("to_data", {16'd0, bus.data}, 32'hFF00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
